// File: rtl/aes_pkg.sv
// Shared AES column-mix definitions: GF(2^8) helpers, FSM states and column layout constants.
package aes_pkg;

  localparam int unsigned COL_W    = 32;
  localparam int unsigned NUM_COLS = 4;

  localparam logic MODE_INV = 1'b0;
  localparam logic MODE_FWD = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using the xtime chain a, 2a, 4a, 8a.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on a single 32-bit column, row 0 in the MSB byte.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             mode_i,
  output logic [COL_W-1:0] col_o
);

  // coef[k] multiplies a[(i+k) mod 4] when forming output row i.
  logic [3:0][3:0] coef;

  always_comb begin
    coef = (mode_i == MODE_FWD) ? {4'd1, 4'd1, 4'd3, 4'd2} : {4'd9, 4'd13, 4'd11, 4'd14};
    col_o = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        col_o[31-8*i -: 8] = col_o[31-8*i -: 8] ^ gf_mul(col_i[31-8*j -: 8], coef[(j+4-i)%4]);
      end
    end
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative (Inv)MixColumns stage: accepts a 128-bit state, transforms COLS_PER_CYCLE columns
// per clock in a working register, then holds the result until the downstream handshake.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_param_chk
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CntStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastCnt = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic [127:0] work_q, work_d;

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gen_cols
    assign col_idx[g] = cnt_q + 2'(g);
    assign col_in[g]  = work_q[COL_W*(NUM_COLS-1-int'(col_idx[g])) +: COL_W];

    mix_column_unit u_mix (
      .col_i  (col_in[g]),
      .mode_i (mode_q),
      .col_o  (col_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          work_d[COL_W*(NUM_COLS-1-int'(col_idx[g])) +: COL_W] = col_out[g];
        end
        cnt_d = cnt_q + CntStep;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= MODE_INV;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign out_data = work_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed and random checks of inv_mix_columns_iter at COLS_PER_CYCLE = 1, 2 and 4.
module tb_inv_mix_columns_iter;

  localparam logic [127:0] V_INV_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_INV_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
  localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;

  logic         sw_in_valid, sw_in_mode, sw_out_ready;
  logic [127:0] sw_in_data;
  logic         d2_in_ready, d2_out_valid, d2_busy;
  logic         d4_in_ready, d4_out_valid, d4_busy;
  logic [127:0] d2_out_data, d4_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(d2_in_ready),
    .in_mode(sw_in_mode), .in_data(sw_in_data), .out_valid(d2_out_valid),
    .out_ready(sw_out_ready), .out_data(d2_out_data), .busy(d2_busy)
  );

  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(d4_in_ready),
    .in_mode(sw_in_mode), .in_data(sw_in_data), .out_valid(d4_out_valid),
    .out_ready(sw_out_ready), .out_data(d4_out_data), .busy(d4_busy)
  );

  // Shift-and-add GF(2^8) multiply, independent of the xtime-chain form used in the design.
  function automatic logic [7:0] ref_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic m);
    logic [7:0]   kf [4];
    logic [7:0]   ki [4];
    logic [7:0]   acc;
    logic [127:0] r;
    kf = '{8'd2, 8'd3, 8'd1, 8'd1};
    ki = '{8'd14, 8'd11, 8'd13, 8'd9};
    r  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ ref_mul(d[127-32*c-8*j -: 8], m ? kf[(j+4-row)%4] : ki[(j+4-row)%4]);
        end
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic send(input logic mode, input logic [127:0] data, output bit ok);
    ok       = 1'b0;
    in_mode  = mode;
    in_data  = data;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles, output bit ok);
    cycles = 0;
    ok     = out_valid;
    while (!ok && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      ok = out_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, busy});
    end
    n_checks++;
    if (out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    n_checks++;
    if ({d2_in_ready, d2_busy, d4_in_ready, d4_busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_sweep: got %b want 1010", {d2_in_ready, d2_busy, d4_in_ready, d4_busy});
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_inverse();
    bit ok;
    out_ready = 1'b1;
    send(1'b0, V_INV_IN, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL inv_accept: got timeout want accept");
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (k < 4) begin
        if ({out_valid, in_ready, busy} !== 3'b001) begin
          n_fail++;
          $display("FAIL inv_latency edge %0d: got %b want 001", k, {out_valid, in_ready, busy});
        end
      end else begin
        if ({out_valid, in_ready} !== 2'b10 || out_data !== V_INV_OUT) begin
          n_fail++;
          $display("FAIL inv_result: got v=%b d=%h want v=1 d=%h", out_valid, out_data, V_INV_OUT);
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL inv_release: got %b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_forward();
    bit ok;
    int cyc;
    out_ready = 1'b1;
    send(1'b1, V_FWD_IN, ok);
    wait_valid(cyc, ok);
    n_checks++;
    if (!ok || out_data !== V_FWD_OUT) begin
      n_fail++;
      $display("FAIL fwd_result: got v=%b d=%h want v=1 d=%h", ok, out_data, V_FWD_OUT);
    end
    send(1'b0, V_FWD_OUT, ok);
    wait_valid(cyc, ok);
    n_checks++;
    if (!ok || out_data !== V_FWD_IN) begin
      n_fail++;
      $display("FAIL fwd_roundtrip: got v=%b d=%h want v=1 d=%h", ok, out_data, V_FWD_IN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    out_ready = 1'b0;
    send(1'b0, V_INV_IN, ok);
    wait_valid(cyc, ok);
    n_checks++;
    if (!ok || out_data !== V_INV_OUT) begin
      n_fail++;
      $display("FAIL bp_result: got v=%b d=%h want v=1 d=%h", ok, out_data, V_INV_OUT);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_mode  = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10 || out_data !== V_INV_OUT) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got v/r=%b d=%h want 10 d=%h", i,
                 {out_valid, in_ready}, out_data, V_INV_OUT);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release: got %b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    int cyc;
    out_ready = 1'b1;
    send(1'b1, V_FWD_IN, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_busy: got flags=%b d=%h want 100 d=0", {in_ready, out_valid, busy},
               out_data);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_no_partial: got %b want 10", {in_ready, out_valid});
    end
    send(1'b0, V_INV_IN, ok);
    wait_valid(cyc, ok);
    n_checks++;
    if (!ok || cyc != 4 || out_data !== V_INV_OUT) begin
      n_fail++;
      $display("FAIL rst_recover: got v=%b lat=%0d d=%h want v=1 lat=4 d=%h", ok, cyc, out_data,
               V_INV_OUT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    sw_in_mode   = 1'b0;
    sw_in_data   = V_INV_IN;
    sw_out_ready = 1'b0;
    sw_in_valid  = 1'b1;
    n_checks++;
    if ({d2_in_ready, d4_in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL sweep_ready: got %b want 11", {d2_in_ready, d4_in_ready});
    end
    @(posedge clk); #1;
    sw_in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (d4_out_valid !== 1'b1 || d4_out_data !== V_INV_OUT || d2_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_c4: got v4=%b d4=%h v2=%b want v4=1 d4=%h v2=0", d4_out_valid,
               d4_out_data, d2_out_valid, V_INV_OUT);
    end
    @(posedge clk); #1;
    n_checks++;
    if (d2_out_valid !== 1'b1 || d2_out_data !== V_INV_OUT) begin
      n_fail++;
      $display("FAIL sweep_c2: got v2=%b d2=%h want v2=1 d2=%h", d2_out_valid, d2_out_data,
               V_INV_OUT);
    end
    sw_out_ready = 1'b1;
    @(posedge clk); #1;
    sw_out_ready = 1'b0;
    n_checks++;
    if ({d2_out_valid, d2_in_ready, d2_busy, d4_out_valid, d4_in_ready, d4_busy} !== 6'b010010) begin
      n_fail++;
      $display("FAIL sweep_release: got %b want 010010",
               {d2_out_valid, d2_in_ready, d2_busy, d4_out_valid, d4_in_ready, d4_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q[$];
    logic [127:0] nd, expd;
    logic         nm;
    int           sent, recv, cycles;
    sent   = 0;
    recv   = 0;
    cycles = 0;
    nd     = {$urandom, $urandom, $urandom, $urandom};
    nm     = 1'($urandom_range(0, 1));
    while (recv < 1000 && cycles < 60000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = nd;
      in_mode   = nm;
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        q.push_back(ref_mix(nd, nm));
        sent++;
        nd = {$urandom, $urandom, $urandom, $urandom};
        nm = 1'($urandom_range(0, 1));
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got output %h want none", out_data);
        end else begin
          expd = q.pop_front();
          if (out_data !== expd) begin
            n_fail++;
            $display("FAIL b2b_data #%0d: got %h want %h", recv, out_data, expd);
          end
        end
        recv++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (sent != 1000 || recv != 1000 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got sent=%0d recv=%0d pending=%0d want 1000/1000/0", sent, recv,
               q.size());
    end
  endtask

  initial begin
    in_valid     = 1'b0;
    in_mode      = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    sw_in_valid  = 1'b0;
    sw_in_mode   = 1'b0;
    sw_in_data   = '0;
    sw_out_ready = 1'b0;
    test_reset();
    test_inverse();
    test_forward();
    test_backpressure();
    test_reset_mid_busy();
    test_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
